// File: rtl/fpu_issue_ctrl_if.sv
// Execute-stage <-> FP issue sequencer handshake: request payload in; stall, done and result back.
interface fpu_issue_ctrl_if;
    localparam int unsigned XLEN = 32;

    logic            req_valid;
    logic [4:0]      req_funct5;
    logic [2:0]      req_rm;
    logic [XLEN-1:0] req_rd1;
    logic [XLEN-1:0] req_rd2;
    logic            busy;
    logic            done;
    logic [XLEN-1:0] result;

    modport master (
        output req_valid, req_funct5, req_rm, req_rd1, req_rd2,
        input  busy, done, result
    );

    modport slave (
        input  req_valid, req_funct5, req_rm, req_rd1, req_rd2,
        output busy, done, result
    );
endinterface

// File: rtl/fpu_issue_ctrl.sv
// Multi-cycle issue sequencer in front of the shared FPU: latches one op, counts its latency, returns the result.
// Optional flush input (branch mispredict / trap) enabled by defining FPU_ISSUE_FLUSH_EN.
module fpu_issue_ctrl #(
    parameter int unsigned LAT_ADDSUB = 2,
    parameter int unsigned LAT_MUL    = 2,
    parameter int unsigned LAT_DIV    = 8,
    parameter int unsigned LAT_SQRT   = 6,
    parameter int unsigned LAT_MISC   = 1
) (
    input  logic                clk,
    input  logic                rst,
    fpu_issue_ctrl_if.slave     req,
    output logic [31:0]         fpu_rd1,
    output logic [31:0]         fpu_rd2,
    output logic [2:0]          fpu_rm,
    output logic [4:0]          fpu_funct5,
    input  logic [31:0]         fpu_result
`ifdef FPU_ISSUE_FLUSH_EN
    ,
    input  logic                flush
`endif
);
    localparam int unsigned XLEN  = 32;
    localparam int unsigned CNT_W = 4;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_EXEC = 2'd1,
        ST_DONE = 2'd2
    } state_e;

    state_e           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [XLEN-1:0]  result_q, result_d;
    logic [XLEN-1:0]  rd1_q, rd1_d;
    logic [XLEN-1:0]  rd2_q, rd2_d;
    logic [2:0]       rm_q, rm_d;
    logic [4:0]       funct5_q, funct5_d;
    logic             done_q, done_d;
    logic             flush_w;

`ifdef FPU_ISSUE_FLUSH_EN
    assign flush_w = flush;
`else
    assign flush_w = 1'b0;
`endif

    // Counter preload: latency minus one, since the accept edge already starts the first EXEC cycle.
    function automatic logic [CNT_W-1:0] lat_minus1(input logic [4:0] f5);
        int unsigned lat;
        case (f5)
            5'b00000, 5'b00001: lat = LAT_ADDSUB;
            5'b00010:           lat = LAT_MUL;
            5'b00011:           lat = LAT_DIV;
            5'b01011:           lat = LAT_SQRT;
            default:            lat = LAT_MISC;
        endcase
        return CNT_W'(lat - 32'd1);
    endfunction

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        result_d = result_q;
        rd1_d    = rd1_q;
        rd2_d    = rd2_q;
        rm_d     = rm_q;
        funct5_d = funct5_q;
        done_d   = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (req.req_valid && !flush_w) begin
                    rd1_d    = req.req_rd1;
                    rd2_d    = req.req_rd2;
                    rm_d     = req.req_rm;
                    funct5_d = req.req_funct5;
                    cnt_d    = lat_minus1(req.req_funct5);
                    state_d  = ST_EXEC;
                end
            end
            ST_EXEC: begin
                if (flush_w) begin
                    state_d = ST_IDLE;
                end else if (cnt_q != '0) begin
                    cnt_d = cnt_q - CNT_W'(1);
                end else begin
                    result_d = fpu_result;
                    done_d   = 1'b1;
                    state_d  = ST_DONE;
                end
            end
            ST_DONE: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q  <= ST_IDLE;
            cnt_q    <= '0;
            result_q <= '0;
            rd1_q    <= '0;
            rd2_q    <= '0;
            rm_q     <= '0;
            funct5_q <= '0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            result_q <= result_d;
            rd1_q    <= rd1_d;
            rd2_q    <= rd2_d;
            rm_q     <= rm_d;
            funct5_q <= funct5_d;
            done_q   <= done_d;
        end
    end

    // Stall covers the request cycle and every EXEC cycle; DONE lets the pipeline advance.
    assign req.busy   = ((state_q == ST_IDLE) && req.req_valid && !flush_w) || (state_q == ST_EXEC);
    assign req.done   = done_q && !flush_w;
    assign req.result = result_q;

    assign fpu_rd1    = rd1_q;
    assign fpu_rd2    = rd2_q;
    assign fpu_rm     = rm_q;
    assign fpu_funct5 = funct5_q;
endmodule

// File: tb/tb_fpu_issue_ctrl.sv
// Directed, table-driven bench for fpu_issue_ctrl with hand-written reset/back-to-back/flush sequences.
module tb_fpu_issue_ctrl;
    logic        clk;
    logic        rst;
    logic [31:0] fpu_rd1, fpu_rd2, fpu_result;
    logic [2:0]  fpu_rm;
    logic [4:0]  fpu_funct5;
`ifdef FPU_ISSUE_FLUSH_EN
    logic        flush;
`endif

    fpu_issue_ctrl_if bus ();

    fpu_issue_ctrl dut (
        .clk        (clk),
        .rst        (rst),
        .req        (bus),
        .fpu_rd1    (fpu_rd1),
        .fpu_rd2    (fpu_rd2),
        .fpu_rm     (fpu_rm),
        .fpu_funct5 (fpu_funct5),
        .fpu_result (fpu_result)
`ifdef FPU_ISSUE_FLUSH_EN
        ,
        .flush      (flush)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // FPU stand-in: the fadd example from the datasheet, integer sum for everything else.
    always_comb begin
        if (fpu_funct5 == 5'b00000 && fpu_rd1 == 32'h3F80_0000 && fpu_rd2 == 32'h4000_0000)
            fpu_result = 32'h4040_0000;
        else
            fpu_result = fpu_rd1 + fpu_rd2;
    end

    typedef struct {
        logic [4:0]  f5;
        logic [2:0]  rm;
        logic [31:0] rd1;
        logic [31:0] rd2;
        int          busy_cycles;
        logic [31:0] exp_result;
    } vec_t;

    vec_t vecs [8];
    int   n_cmp = 0;
    int   n_bad = 0;

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic drive_req(input logic v, input logic [4:0] f5, input logic [2:0] rm,
                             input logic [31:0] a, input logic [31:0] b);
        bus.req_valid  = v;
        bus.req_funct5 = f5;
        bus.req_rm     = rm;
        bus.req_rd1    = a;
        bus.req_rd2    = b;
    endtask

    // Starts at a negedge in IDLE; holds the request until done, then drops it.
    task automatic run_vec(input vec_t v, input string tag);
        int busy_n  = 0;
        int done_at = -1;
        bit stable  = 1'b1;
        drive_req(1'b1, v.f5, v.rm, v.rd1, v.rd2);
        for (int c = 0; c < 40 && done_at < 0; c++) begin
            #1;
            if (bus.busy) busy_n++;
            if (c > 0 && (fpu_funct5 !== v.f5 || fpu_rd1 !== v.rd1 || fpu_rd2 !== v.rd2)) stable = 1'b0;
            if (bus.done) begin
                done_at = c;
                check({tag, " result"}, bus.result, v.exp_result);
                check({tag, " busy in done"}, {31'b0, bus.busy}, 32'd0);
                bus.req_valid = 1'b0;
            end
            @(negedge clk);
        end
        check({tag, " busy cycles"}, 32'(busy_n), 32'(v.busy_cycles));
        check({tag, " done cycle"}, 32'(done_at), 32'(v.busy_cycles));
        check({tag, " fpu inputs stable"}, {31'b0, stable}, 32'd1);
        #1;
        check({tag, " done one cycle"}, {31'b0, bus.done}, 32'd0);
        check({tag, " fpu_rm"}, {29'b0, fpu_rm}, {29'b0, v.rm});
        check({tag, " result held"}, bus.result, v.exp_result);
        @(negedge clk);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [24:0] busy_pat, done_pat, exp_busy, exp_done;
        int          ndone;

        vecs[0] = '{5'b00000, 3'd0, 32'h3F80_0000, 32'h4000_0000, 3, 32'h4040_0000};
        vecs[1] = '{5'b00001, 3'd1, 32'h0000_1000, 32'h0000_0234, 3, 32'h0000_1234};
        vecs[2] = '{5'b00010, 3'd2, 32'h1000_0000, 32'h0000_0005, 3, 32'h1000_0005};
        vecs[3] = '{5'b00011, 3'd3, 32'h1234_0000, 32'h0000_5678, 9, 32'h1234_5678};
        vecs[4] = '{5'b01011, 3'd4, 32'hA000_0000, 32'h0000_000B, 7, 32'hA000_000B};
        vecs[5] = '{5'b00100, 3'd0, 32'h0000_0100, 32'h0000_0023, 2, 32'h0000_0123};
        vecs[6] = '{5'b11111, 3'd7, 32'hCAFE_0000, 32'h0000_BABE, 2, 32'hCAFE_BABE};
        vecs[7] = '{5'b00101, 3'd1, 32'h0F0F_0000, 32'h0000_0F0F, 2, 32'h0F0F_0F0F};

        // Reset with junk payload
        rst = 1'b0;
`ifdef FPU_ISSUE_FLUSH_EN
        flush = 1'b0;
`endif
        drive_req(1'b0, 5'($urandom), 3'($urandom), $urandom, $urandom);
        repeat (2) @(negedge clk);
        #1;
        check("reset busy", {31'b0, bus.busy}, 32'd0);
        check("reset done", {31'b0, bus.done}, 32'd0);
        check("reset result", bus.result, 32'd0);
        check("reset fpu_rd1", fpu_rd1, 32'd0);
        check("reset fpu_rd2", fpu_rd2, 32'd0);
        check("reset fpu_ctl", {24'b0, fpu_funct5, fpu_rm}, 32'd0);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);

        for (int i = 0; i < 8; i++) run_vec(vecs[i], $sformatf("vec%0d", i));

        // fdiv then fsgnj back to back; second request presented during DONE
        busy_pat = '0; done_pat = '0; ndone = 0;
        drive_req(1'b1, 5'b00011, 3'd0, 32'h4000_0000, 32'h0000_0001);
        for (int c = 0; c < 25; c++) begin
            #1;
            busy_pat[c] = bus.busy;
            done_pat[c] = bus.done;
            if (c == 9) check("b2b funct5 in done", {27'b0, fpu_funct5}, 32'h3);
            if (c == 11) check("b2b second funct5", {27'b0, fpu_funct5}, 32'h4);
            if (bus.done) begin
                ndone++;
                if (ndone == 1) begin
                    check("b2b fdiv result", bus.result, 32'h4000_0001);
                    drive_req(1'b1, 5'b00100, 3'd0, 32'h0000_0111, 32'h0000_0222);
                end else begin
                    check("b2b fsgnj result", bus.result, 32'h0000_0333);
                    bus.req_valid = 1'b0;
                end
            end
            @(negedge clk);
        end
        exp_busy = '0; exp_done = '0;
        for (int c = 0; c <= 8; c++) exp_busy[c] = 1'b1;
        exp_busy[10] = 1'b1; exp_busy[11] = 1'b1;
        exp_done[9]  = 1'b1; exp_done[12] = 1'b1;
        check("b2b busy pattern", {7'b0, busy_pat}, {7'b0, exp_busy});
        check("b2b done pattern", {7'b0, done_pat}, {7'b0, exp_done});
        bus.req_valid = 1'b0;

        // Async reset during cycle 4 of an fdiv
        drive_req(1'b1, 5'b00011, 3'd2, 32'h1111_0000, 32'h0000_2222);
        repeat (4) @(negedge clk);
        rst = 1'b0;
        bus.req_valid = 1'b0;
        #1;
        check("midreset busy", {31'b0, bus.busy}, 32'd0);
        check("midreset result", bus.result, 32'd0);
        check("midreset fpu_rd1", fpu_rd1, 32'd0);
        check("midreset fpu_ctl", {24'b0, fpu_funct5, fpu_rm}, 32'd0);
        ndone = 0;
        for (int c = 0; c < 10; c++) begin
            @(negedge clk);
            if (c == 3) rst = 1'b1;
            #1;
            if (bus.done) ndone++;
        end
        check("midreset no done", 32'(ndone), 32'd0);
        @(negedge clk);
        run_vec(vecs[1], "post-reset");

`ifdef FPU_ISSUE_FLUSH_EN
        begin
            logic [31:0] prev;
            prev = bus.result;
            // Flush in IDLE blocks the accept
            drive_req(1'b1, 5'b11000, 3'd5, 32'h5555_5555, 32'h0);
            flush = 1'b1;
            #1;
            check("flush idle busy", {31'b0, bus.busy}, 32'd0);
            @(negedge clk);
            flush = 1'b0;
            bus.req_valid = 1'b0;
            #1;
            check("flush idle no accept", {27'b0, fpu_funct5}, 32'h1);
            @(negedge clk);

            // Flush during fsqrt EXEC
            drive_req(1'b1, 5'b01011, 3'd0, 32'h0000_0700, 32'h0000_0007);
            repeat (3) @(negedge clk);
            flush = 1'b1;
            bus.req_valid = 1'b0;
            @(negedge clk);
            flush = 1'b0;
            #1;
            check("flush exec busy", {31'b0, bus.busy}, 32'd0);
            ndone = 0;
            for (int c = 0; c < 10; c++) begin
                @(negedge clk);
                #1;
                if (bus.done) ndone++;
            end
            check("flush exec no done", 32'(ndone), 32'd0);
            check("flush exec result kept", bus.result, prev);
            @(negedge clk);

            // Flush coincident with DONE
            drive_req(1'b1, vecs[0].f5, vecs[0].rm, vecs[0].rd1, vecs[0].rd2);
            ndone = 0;
            for (int c = 0; c < 20 && ndone == 0; c++) begin
                @(negedge clk);
                #1;
                if (bus.done) ndone++;
            end
            check("flush done reached", 32'(ndone), 32'd1);
            flush = 1'b1;
            #1;
            check("flush done gated", {31'b0, bus.done}, 32'd0);
            @(negedge clk);
            flush = 1'b0;
            bus.req_valid = 1'b0;
            #1;
            check("flush done idle busy", {31'b0, bus.busy}, 32'd0);
            check("flush done idle done", {31'b0, bus.done}, 32'd0);
            @(negedge clk);
        end
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
